// File: rtl/rvnoob_pkg.sv
// Shared constants and types for the rvnoob core front end.
// Holds architectural widths, reset PC, well-known encodings and the fetch FSM states.
package rvnoob_pkg;

    localparam int XLEN   = 64;
    localparam int INST_W = 32;

    localparam logic [63:0] RESET_PC    = 64'h8000_0000;
    localparam logic [31:0] NOP_INST    = 32'h0000_0013;
    localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_HALT = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_pc_reg.sv
// Fetch PC register: halt freezes it, redirect loads a word-aligned target, advance adds 4.
// Latency: new value visible the cycle after the update; no backpressure of its own.
module fetch_pc_reg
    import rvnoob_pkg::*;
#(
    parameter int              PC_W   = XLEN,
    parameter logic [PC_W-1:0] PC_RST = RESET_PC
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            halt,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    input  logic            advance,
    output logic [PC_W-1:0] pc_q,
    output logic [PC_W-1:0] pc_next
);

    logic [PC_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (halt) begin
            pc_d = pc_q;
        end else if (redirect_valid) begin
            pc_d = {redirect_pc[PC_W-1:2], 2'b00};
        end else if (advance) begin
            // wraps modulo 2^PC_W without any fault
            pc_d = pc_q + {{(PC_W-3){1'b0}}, 3'd4};
        end
    end

    assign pc_next = pc_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q <= PC_RST;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch: one outstanding imem request, result held until decode takes it.
// Latency: 3 cycles per instruction at best; stalls on imem_req_ready / out_ready, stops forever on halt.
module ifu_fetch #(
    parameter int               XLEN     = rvnoob_pkg::XLEN,
    parameter int               INST_W   = rvnoob_pkg::INST_W,
    parameter logic [XLEN-1:0]  RESET_PC = rvnoob_pkg::RESET_PC
) (
    input  logic              clock,
    input  logic              reset,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [XLEN-1:0]   imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [INST_W-1:0] imem_resp_data,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    input  logic              halt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [XLEN-1:0]   out_pc,
    output logic              halted
);

    rvnoob_pkg::fetch_state_e state_q, state_d;
    logic              drop_q, drop_d;
    logic [INST_W-1:0] out_inst_q, out_inst_d;
    logic [XLEN-1:0]   out_pc_q, out_pc_d;
    logic              halted_q, halted_d;

    logic              redir_take;
    logic              pc_adv;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   pc_next_unused;

    fetch_pc_reg #(
        .PC_W   (XLEN),
        .PC_RST (RESET_PC)
    ) u_pc (
        .clock          (clock),
        .reset          (reset),
        .halt           (halt),
        .redirect_valid (redir_take),
        .redirect_pc    (redirect_pc),
        .advance        (pc_adv),
        .pc_q           (pc),
        .pc_next        (pc_next_unused)
    );

    always_comb begin
        state_d        = state_q;
        drop_d         = drop_q;
        out_inst_d     = out_inst_q;
        out_pc_d       = out_pc_q;
        halted_d       = halted_q;
        imem_req_valid = 1'b0;
        out_valid      = 1'b0;
        redir_take     = 1'b0;
        pc_adv         = 1'b0;

        if (halt) begin
            state_d  = rvnoob_pkg::S_HALT;
            halted_d = 1'b1;
        end else begin
            case (state_q)
                rvnoob_pkg::S_REQ: begin
                    imem_req_valid = !redirect_valid;
                    if (redirect_valid) begin
                        redir_take = 1'b1;
                    end else if (imem_req_ready) begin
                        state_d = rvnoob_pkg::S_WAIT;
                    end
                end
                rvnoob_pkg::S_WAIT: begin
                    if (redirect_valid) begin
                        redir_take = 1'b1;
                        // a same-cycle response is the stale one, so nothing is left to drop
                        if (imem_resp_valid) begin
                            drop_d  = 1'b0;
                            state_d = rvnoob_pkg::S_REQ;
                        end else begin
                            drop_d = 1'b1;
                        end
                    end else if (imem_resp_valid) begin
                        if (drop_q) begin
                            drop_d  = 1'b0;
                            state_d = rvnoob_pkg::S_REQ;
                        end else begin
                            out_inst_d = imem_resp_data;
                            out_pc_d   = pc;
                            pc_adv     = 1'b1;
                            state_d    = rvnoob_pkg::S_HOLD;
                        end
                    end
                end
                rvnoob_pkg::S_HOLD: begin
                    out_valid = !redirect_valid;
                    if (redirect_valid) begin
                        redir_take = 1'b1;
                        state_d    = rvnoob_pkg::S_REQ;
                    end else if (out_ready) begin
                        state_d = rvnoob_pkg::S_REQ;
                    end
                end
                default: begin
                    state_d = rvnoob_pkg::S_HALT;
                end
            endcase
        end

        if (reset) begin
            imem_req_valid = 1'b0;
            out_valid      = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= rvnoob_pkg::S_REQ;
            drop_q     <= 1'b0;
            out_inst_q <= rvnoob_pkg::NOP_INST;
            out_pc_q   <= RESET_PC;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            drop_q     <= drop_d;
            out_inst_q <= out_inst_d;
            out_pc_q   <= out_pc_d;
            halted_q   <= halted_d;
        end
    end

    assign imem_req_addr = pc;
    assign out_inst      = out_inst_q;
    assign out_pc        = out_pc_q;
    assign halted        = halted_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: cycle table, directed halt/wrap sequences, then random traffic
// compared against a transaction-level model of the fetch contract.
module tb_ifu_fetch;

    localparam logic [63:0] A0  = 64'h8000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        halt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [63:0] out_pc;
    logic        halted;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    ifu_fetch dut (
        .clock           (clock),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .halt            (halt),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_inst        (out_inst),
        .out_pc          (out_pc),
        .halted          (halted)
    );

    typedef struct {
        logic        rq_rdy;
        logic        rs_vld;
        logic [31:0] rs_dat;
        logic        rd_vld;
        logic [63:0] rd_pc;
        logic        hlt;
        logic        o_rdy;
        logic        e_req;
        logic [63:0] e_addr;
        logic        e_ovld;
        logic [31:0] e_inst;
        logic [63:0] e_opc;
        logic        e_halted;
    } vec_t;

    vec_t tbl [20];

    function automatic vec_t mk(input logic rq, input logic rs, input logic [31:0] rsd,
                                input logic rd, input logic [63:0] rdp, input logic h,
                                input logic ordy, input logic er, input logic [63:0] ea,
                                input logic eo, input logic [31:0] ei, input logic [63:0] ep,
                                input logic eh);
        vec_t v;
        v.rq_rdy = rq;  v.rs_vld = rs; v.rs_dat = rsd; v.rd_vld = rd; v.rd_pc = rdp;
        v.hlt = h;      v.o_rdy = ordy;
        v.e_req = er;   v.e_addr = ea; v.e_ovld = eo;  v.e_inst = ei; v.e_opc = ep;
        v.e_halted = eh;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs at the falling edge and let outputs settle.
    task automatic cyc(input logic rq, input logic rs, input logic [31:0] rsd, input logic rd,
                       input logic [63:0] rdp, input logic h, input logic ordy);
        @(negedge clock);
        imem_req_ready  = rq;
        imem_resp_valid = rs;
        imem_resp_data  = rsd;
        redirect_valid  = rd;
        redirect_pc     = rdp;
        halt            = h;
        out_ready       = ordy;
        #1;
    endtask

    // Reset with junk on the inputs: none of it may leak through.
    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        imem_req_ready = 1'b1; imem_resp_valid = 1'b1; imem_resp_data = 32'hDEAD_BEEF;
        redirect_valid = 1'b1; redirect_pc = 64'h1234; halt = 1'b0; out_ready = 1'b1;
        #1;
        chk("reset_req_vld", imem_req_valid, 0);
        chk("reset_out_vld", out_valid, 0);
        @(negedge clock);
        reset = 1'b0;
        imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
        redirect_valid = 1'b0; redirect_pc = 64'h0; out_ready = 1'b0;
    endtask

    // Transaction-level reference state for the random phase
    logic [63:0] m_pc;
    logic        m_halted, m_pend, m_stale, m_held;
    logic [31:0] m_hinst;
    logic [63:0] m_hpc;

    initial begin
        reset = 1'b0;
        imem_req_ready = 0; imem_resp_valid = 0; imem_resp_data = 0;
        redirect_valid = 0; redirect_pc = 0; halt = 0; out_ready = 0;

        tbl[0]  = mk(1,0,32'h0,0,64'h0,0,1,          1,A0,0,NOP,A0,0);
        tbl[1]  = mk(0,1,32'h0000_0513,0,64'h0,0,1,  0,A0,0,NOP,A0,0);
        tbl[2]  = mk(1,0,32'h0,0,64'h0,0,1,          0,A0+4,1,32'h513,A0,0);
        for (int i = 3; i < 8; i++)
            tbl[i] = mk(0,0,32'h0,0,64'h0,0,1,       1,A0+4,0,32'h513,A0,0);
        tbl[8]  = mk(1,0,32'h0,0,64'h0,0,1,          1,A0+4,0,32'h513,A0,0);
        tbl[9]  = mk(0,0,32'h0,1,64'h8000_0103,0,1,  0,A0+4,0,32'h513,A0,0);
        tbl[10] = mk(0,0,32'h0,0,64'h0,0,1,          0,64'h8000_0100,0,32'h513,A0,0);
        tbl[11] = mk(0,1,32'hDEAD_BEEF,0,64'h0,0,1,  0,64'h8000_0100,0,32'h513,A0,0);
        tbl[12] = mk(1,0,32'h0,0,64'h0,0,1,          1,64'h8000_0100,0,32'h513,A0,0);
        tbl[13] = mk(0,1,32'h00A0_0593,0,64'h0,0,1,  0,64'h8000_0100,0,32'h513,A0,0);
        for (int i = 14; i < 18; i++)
            tbl[i] = mk(0,0,32'h0,0,64'h0,0,0,       0,64'h8000_0104,1,32'h00A0_0593,64'h8000_0100,0);
        tbl[18] = mk(0,0,32'h0,1,64'h8000_0200,0,1,  0,64'h8000_0104,0,32'h00A0_0593,64'h8000_0100,0);
        tbl[19] = mk(1,0,32'h0,0,64'h0,0,1,          1,64'h8000_0200,0,32'h00A0_0593,64'h8000_0100,0);

        // ---- table: basic fetch, req stall, redirect in WAIT, redirect kills HOLD ----
        do_reset();
        for (int i = 0; i < 20; i++) begin
            cyc(tbl[i].rq_rdy, tbl[i].rs_vld, tbl[i].rs_dat, tbl[i].rd_vld,
                tbl[i].rd_pc, tbl[i].hlt, tbl[i].o_rdy);
            chk($sformatf("tbl%0d_req_vld", i), imem_req_valid, tbl[i].e_req);
            chk($sformatf("tbl%0d_addr", i),    imem_req_addr,  tbl[i].e_addr);
            chk($sformatf("tbl%0d_out_vld", i), out_valid,      tbl[i].e_ovld);
            chk($sformatf("tbl%0d_out_inst", i), out_inst,      tbl[i].e_inst);
            chk($sformatf("tbl%0d_out_pc", i),  out_pc,         tbl[i].e_opc);
            chk($sformatf("tbl%0d_halted", i),  halted,         tbl[i].e_halted);
        end

        // ---- halt with simultaneous redirect, sticky for 20 cycles, then reset ----
        do_reset();
        cyc(1,0,32'h0,0,64'h0,0,1);
        cyc(0,1,32'h0010_0073,0,64'h0,0,1);
        cyc(0,0,32'h0,0,64'h0,0,1);
        chk("ebreak_out_vld", out_valid, 1);
        chk("ebreak_out_inst", out_inst, 32'h0010_0073);
        cyc(1,0,32'h0,1,64'h8000_0400,1,1);
        chk("halt_cycle_req_vld", imem_req_valid, 0);
        for (int i = 0; i < 20; i++) begin
            cyc(1, i == 5, 32'h13, (i % 3) == 0, 64'h8000_0800, 0, 1);
            chk("halted_sticky", halted, 1);
            chk("halted_req_vld", imem_req_valid, 0);
            chk("halted_out_vld", out_valid, 0);
            chk("halted_pc", imem_req_addr, A0 + 4);
        end
        do_reset();
        cyc(0,0,32'h0,0,64'h0,0,0);
        chk("restart_req_vld", imem_req_valid, 1);
        chk("restart_addr", imem_req_addr, A0);
        chk("restart_halted", halted, 0);
        chk("restart_out_inst", out_inst, NOP);

        // ---- PC wrap, plus a response that arrives outside WAIT ----
        cyc(0,0,32'h0,1,64'hFFFF_FFFF_FFFF_FFFC,0,0);
        cyc(1,0,32'h0,0,64'h0,0,0);
        chk("wrap_req_vld", imem_req_valid, 1);
        chk("wrap_addr", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        cyc(0,1,32'h0000_0013,0,64'h0,0,1);
        cyc(0,0,32'h0,0,64'h0,0,1);
        chk("wrap_out_pc", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_out_vld", out_valid, 1);
        cyc(0,1,32'h0000_0BAD,0,64'h0,0,1);
        chk("wrap_next_addr", imem_req_addr, 64'h0);
        chk("wrap_next_req_vld", imem_req_valid, 1);
        cyc(0,0,32'h0,0,64'h0,0,1);
        chk("spurious_resp_ignored", out_inst, 32'h0000_0013);

        // ---- random traffic vs. model ----
        begin
            int   mem_cnt;
            int   halt_age;
            int   delivered;
            logic exp_req, exp_ovld;
            do_reset();
            m_pc = A0; m_halted = 0; m_pend = 0; m_stale = 0; m_held = 0;
            m_hinst = NOP; m_hpc = A0;
            mem_cnt = 0; halt_age = 0; delivered = 0;
            for (int n = 0; n < 3000; n++) begin
                @(negedge clock);
                if (m_halted && halt_age >= 8) begin
                    reset = 1'b1;
                    imem_resp_valid = 1'b0;
                    halt = 1'b0;
                    #1;
                    chk("rand_reset_req_vld", imem_req_valid, 0);
                    m_pc = A0; m_halted = 0; m_pend = 0; m_stale = 0; m_held = 0;
                    mem_cnt = 0; halt_age = 0;
                    continue;
                end
                reset           = 1'b0;
                imem_req_ready  = ($urandom % 4) != 0;
                imem_resp_valid = (mem_cnt == 1);
                imem_resp_data  = $urandom;
                redirect_valid  = ($urandom % 12) == 0;
                redirect_pc     = (($urandom % 4) == 0) ? {32'hFFFF_FFFF, $urandom}
                                                        : {$urandom, $urandom};
                halt            = ($urandom % 150) == 0;
                out_ready       = ($urandom % 3) != 0;
                #1;

                exp_req  = !m_halted && !m_pend && !m_held && !redirect_valid && !halt;
                exp_ovld = !m_halted && m_held && !redirect_valid && !halt;
                chk("rand_req_vld", imem_req_valid, exp_req);
                chk("rand_out_vld", out_valid, exp_ovld);
                chk("rand_halted", halted, m_halted);
                if (exp_req)  chk("rand_addr", imem_req_addr, m_pc);
                if (exp_ovld) begin
                    chk("rand_out_inst", out_inst, m_hinst);
                    chk("rand_out_pc", out_pc, m_hpc);
                end

                if (halt) begin
                    m_halted = 1'b1;
                end else if (!m_halted) begin
                    if (imem_resp_valid && m_pend) begin
                        if (!m_stale && !redirect_valid) begin
                            m_held  = 1'b1;
                            m_hinst = imem_resp_data;
                            m_hpc   = m_pc;
                            m_pc    = m_pc + 64'd4;
                        end
                        m_pend  = 1'b0;
                        m_stale = 1'b0;
                    end
                    if (exp_req && imem_req_ready) m_pend = 1'b1;
                    if (exp_ovld && out_ready) begin
                        m_held = 1'b0;
                        delivered++;
                    end
                    if (redirect_valid) begin
                        m_pc = redirect_pc & ~64'd3;
                        if (m_pend) m_stale = 1'b1;
                        m_held = 1'b0;
                    end
                end
                if (m_halted) halt_age++;

                if (imem_resp_valid) mem_cnt = 0;
                else if (mem_cnt > 0) mem_cnt--;
                if (imem_req_valid && imem_req_ready) mem_cnt = $urandom_range(1, 3);
            end
            chk("rand_delivered_some", delivered > 50, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
